// File: rtl/pll_dps_responder.sv
`timescale 1ns/1ps
// PLL dynamic phase-shift responder: six wrapping phase offsets stepped over a scanclk handshake.
// Latency: phase_done falls 4 clk after a raw scanclk rise. Flow control: phase_done low = busy, steps ignored.
// Optional step counter on step_total is built only when PLL_DPS_STEPLOG_EN is defined.
module pll_dps_responder #(
    parameter int PHASE_MOD = 24,
    parameter int DONE_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scanclk,
    input  logic        phasestep,
    input  logic [2:0]  phasecounterselect,
    input  logic        phaseupdown,
    input  logic        pll_areset,
    output logic        phase_done,
    input  logic [2:0]  rd_sel,
    output logic [7:0]  rd_phase,
    output logic        sel_err,
    output logic [15:0] step_total
);
    localparam int CW = $clog2(DONE_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, REARM} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          nxt_done, do_step, do_err;

    logic [1:0] scan_sync, step_sync, ud_sync;
    logic [2:0] sel_s1, sel_s2;
    logic       scan_q, sr;
    logic [2:0] live;
    logic [7:0] offs [6];
    logic [7:0] rd_val;

    function automatic logic [7:0] bump(input logic [7:0] v, input logic up);
        if (up) return (v == 8'(PHASE_MOD - 1)) ? 8'd0 : v + 8'd1;
        else    return (v == 8'd0) ? 8'(PHASE_MOD - 1) : v - 8'd1;
    endfunction

    // live gates sr until scan_q holds a real post-reset sample, so a
    // scanclk already high at reset release cannot look like a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_sync <= '0;
            step_sync <= '0;
            ud_sync   <= '0;
            sel_s1    <= '0;
            sel_s2    <= '0;
            scan_q    <= 1'b0;
            live      <= '0;
            sr        <= 1'b0;
        end else begin
            scan_sync <= {scan_sync[0], scanclk};
            step_sync <= {step_sync[0], phasestep};
            ud_sync   <= {ud_sync[0], phaseupdown};
            sel_s1    <= phasecounterselect;
            sel_s2    <= sel_s1;
            scan_q    <= scan_sync[1];
            live      <= {live[1:0], 1'b1};
            sr        <= scan_sync[1] & ~scan_q & live[2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            phase_done <= 1'b1;
        end else if (pll_areset) begin
            state      <= IDLE;
            cnt        <= '0;
            phase_done <= 1'b1;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            phase_done <= nxt_done;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_done  = phase_done;
        do_step   = 1'b0;
        do_err    = 1'b0;
        case (state)
            IDLE: if (sr && step_sync[1]) begin
                if (sel_s2 == 3'b111) begin
                    do_err    = 1'b1;
                    nxt_state = REARM;
                end else begin
                    do_step   = 1'b1;
                    nxt_state = BUSY;
                    nxt_done  = 1'b0;
                    nxt_cnt   = '0;
                end
            end
            BUSY: if (sr) begin
                if (cnt == CW'(DONE_LAT - 1)) begin
                    nxt_done  = 1'b1;
                    nxt_state = REARM;
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            REARM: if (sr && !step_sync[1]) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) offs[i] <= '0;
            sel_err <= 1'b0;
        end else if (pll_areset) begin
            for (int i = 0; i < 6; i++) offs[i] <= '0;
            sel_err <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++)
                if (do_step && (sel_s2 == 3'd0 || sel_s2 == 3'(i + 1)))
                    offs[i] <= bump(offs[i], ud_sync[1]);
            if (do_err) sel_err <= 1'b1;
        end
    end

    // Index 0 (M) doubles as the answer for the "all" and reserved selects.
    always_comb begin
        rd_val = offs[0];
        case (rd_sel)
            3'd2:    rd_val = offs[1];
            3'd3:    rd_val = offs[2];
            3'd4:    rd_val = offs[3];
            3'd5:    rd_val = offs[4];
            3'd6:    rd_val = offs[5];
            default: rd_val = offs[0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_phase <= '0;
        else       rd_phase <= rd_val;
    end

`ifdef PLL_DPS_STEPLOG_EN
    logic [15:0] step_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  step_cnt <= '0;
        else if (pll_areset)                        step_cnt <= '0;
        else if (do_step && step_cnt != 16'hFFFF)   step_cnt <= step_cnt + 16'd1;
    end
    assign step_total = step_cnt;
`else
    assign step_total = '0;
`endif

endmodule

// File: tb/tb_pll_dps_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for pll_dps_responder: expected offsets queued at stimulus time, popped at readback.
module tb_pll_dps_responder;
    localparam int PM = 24;
    localparam int DL = 2;

    logic        clk = 1'b0;
    logic        reset, scanclk, phasestep, phaseupdown, pll_areset;
    logic [2:0]  pcs, rd_sel;
    logic        phase_done, sel_err;
    logic [7:0]  rd_phase;
    logic [15:0] step_total;

    pll_dps_responder #(.PHASE_MOD(PM), .DONE_LAT(DL)) dut (
        .clk(clk), .reset(reset), .scanclk(scanclk), .phasestep(phasestep),
        .phasecounterselect(pcs), .phaseupdown(phaseupdown), .pll_areset(pll_areset),
        .phase_done(phase_done), .rd_sel(rd_sel), .rd_phase(rd_phase),
        .sel_err(sel_err), .step_total(step_total)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic done_q = 1'b1;
    logic [7:0] exp_q [$];
    int model [6];
    int model_steps = 0;

    always @(negedge clk) begin
        done_q <= phase_done;
        if (done_q === 1'b1 && phase_done === 1'b0) pulses <= pulses + 1;
    end

    task automatic scan_cycle();
        @(posedge clk); #3 scanclk = 1'b1;
        repeat (4) @(posedge clk);
        #3 scanclk = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 6; i++) model[i] = 0;
        model_steps = 0;
    endtask

    task automatic model_step(input logic [2:0] s, input logic up);
        for (int i = 0; i < 6; i++)
            if (s == 3'd0 || s == 3'(i + 1))
                model[i] = up ? (model[i] + 1) % PM : (model[i] + PM - 1) % PM;
        model_steps++;
    endtask

    task automatic full_step(input logic [2:0] s, input logic up);
        pcs = s; phaseupdown = up; phasestep = 1'b1;
        scan_cycle();
        phasestep = 1'b0;
        repeat (DL + 1) scan_cycle();
        if (s != 3'b111) model_step(s, up);
    endtask

    task automatic areset_pulse();
        @(posedge clk); #3 pll_areset = 1'b1;
        @(posedge clk); #3 pll_areset = 1'b0;
        model_clear();
    endtask

    task automatic read_off(input logic [2:0] s, output logic [7:0] v);
        rd_sel = s;
        repeat (2) @(posedge clk);
        #1 v = rd_phase;
    endtask

    function automatic int exp_total();
`ifdef PLL_DPS_STEPLOG_EN
        return model_steps;
`else
        return 0;
`endif
    endfunction

    task automatic test_reset();
        logic [7:0] v, e;
        int p0;
        reset = 1'b1; scanclk = 1'b1; phasestep = 1'b1; pcs = 3'd2;
        phaseupdown = 1'b1; pll_areset = 1'b0; rd_sel = 3'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (phase_done !== 1'b1) begin n_fail++; $display("FAIL reset_done got %b want 1", phase_done); end
        n_checks++; if (rd_phase !== 8'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", rd_phase); end
        n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", sel_err); end
        n_checks++; if (step_total !== 16'd0) begin n_fail++; $display("FAIL reset_total got %0d want 0", step_total); end
        p0 = pulses;
        @(posedge clk); #3 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (pulses != p0 || phase_done !== 1'b1) begin n_fail++; $display("FAIL high_scan_at_release pulses %0d done %b want %0d 1", pulses, phase_done, p0); end
        phasestep = 1'b0;
        @(posedge clk); #3 scanclk = 1'b0;
        repeat (4) @(posedge clk);
        scan_cycle();
        exp_q.push_back(8'(model[1]));
        read_off(3'd2, v); e = exp_q.pop_front();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL release_c0 got %0d want %0d", v, e); end
    endtask

    task automatic test_latency();
        logic [7:0] v, e;
        int lat;
        areset_pulse();
        pcs = 3'd2; phaseupdown = 1'b1; phasestep = 1'b1;
        repeat (6) @(posedge clk);
        @(posedge clk); #3 scanclk = 1'b1;
        lat = 0;
        while (phase_done === 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL done_latency got %0d clk want 4", lat); end
        repeat (2) @(posedge clk);
        #3 scanclk = 1'b0;
        phasestep = 1'b0;
        repeat (4) @(posedge clk);
        model_step(3'd2, 1'b1);
        scan_cycle(); #1;
        n_checks++; if (phase_done !== 1'b0) begin n_fail++; $display("FAIL done_low_after_1sr got %b want 0", phase_done); end
        scan_cycle(); #1;
        n_checks++; if (phase_done !== 1'b1) begin n_fail++; $display("FAIL done_high_after_2sr got %b want 1", phase_done); end
        scan_cycle();
        exp_q.push_back(8'(model[1]));
        read_off(3'd2, v); e = exp_q.pop_front();
        n_checks++; if (v !== e || v !== 8'd1) begin n_fail++; $display("FAIL c0_after_up got %0d want %0d", v, e); end
    endtask

    task automatic test_all_down();
        logic [7:0] v, e;
        areset_pulse();
        full_step(3'd0, 1'b0);
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(model[i]));
        exp_q.push_back(8'(model[0]));
        for (int i = 1; i <= 7; i++) begin
            read_off(3'(i), v); e = exp_q.pop_front();
            n_checks++; if (v !== e) begin n_fail++; $display("FAIL all_down sel %0d got %0d want %0d", i, v, e); end
        end
        n_checks++; if (step_total !== 16'(exp_total())) begin n_fail++; $display("FAIL all_down_total got %0d want %0d", step_total, exp_total()); end
    endtask

    task automatic test_wrap();
        logic [7:0] v, e;
        int p0;
        areset_pulse();
        p0 = pulses;
        rd_sel = 3'd6;
        for (int i = 0; i < PM; i++) begin
            full_step(3'd6, 1'b1);
            exp_q.push_back(8'(model[5]));
            read_off(3'd6, v); e = exp_q.pop_front();
            n_checks++; if (v !== e) begin n_fail++; $display("FAIL wrap step %0d got %0d want %0d", i + 1, v, e); end
        end
        n_checks++; if (pulses - p0 != PM) begin n_fail++; $display("FAIL wrap_pulses got %0d want %0d", pulses - p0, PM); end
        n_checks++; if (step_total !== 16'(exp_total())) begin n_fail++; $display("FAIL wrap_total got %0d want %0d", step_total, exp_total()); end
    endtask

    task automatic test_hold();
        logic [7:0] v, e;
        int p0;
        p0 = pulses;
        pcs = 3'd1; phaseupdown = 1'b1; phasestep = 1'b1;
        repeat (10) scan_cycle();
        #1;
        n_checks++; if (pulses - p0 != 1 || phase_done !== 1'b1) begin n_fail++; $display("FAIL hold_pulses got %0d done %b want 1 1", pulses - p0, phase_done); end
        model_step(3'd1, 1'b1);
        phasestep = 1'b0;
        scan_cycle();
        n_checks++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL hold_release_pulses got %0d want 1", pulses - p0); end
        exp_q.push_back(8'(model[0]));
        read_off(3'd1, v); e = exp_q.pop_front();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL hold_m got %0d want %0d", v, e); end
    endtask

    task automatic test_reserved();
        logic [7:0] v, e;
        int p0;
        p0 = pulses;
        full_step(3'b111, 1'b1);
        n_checks++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL rsv_err got %b want 1", sel_err); end
        n_checks++; if (pulses != p0 || phase_done !== 1'b1) begin n_fail++; $display("FAIL rsv_done pulses %0d done %b want 0 1", pulses - p0, phase_done); end
        exp_q.push_back(8'(model[0]));
        read_off(3'd1, v); e = exp_q.pop_front();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL rsv_m got %0d want %0d", v, e); end
        areset_pulse();
        @(posedge clk); #1;
        n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL rsv_clear got %b want 0", sel_err); end
    endtask

    task automatic test_areset_busy();
        logic [7:0] v, e;
        areset_pulse();
        pcs = 3'd0; phaseupdown = 1'b1; phasestep = 1'b1;
        scan_cycle();
        phasestep = 1'b0; #1;
        n_checks++; if (phase_done !== 1'b0) begin n_fail++; $display("FAIL busy_entry got %b want 0", phase_done); end
        @(posedge clk); #3 pll_areset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (phase_done !== 1'b1) begin n_fail++; $display("FAIL areset_done got %b want 1", phase_done); end
        #2 pll_areset = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(model[i]));
        for (int i = 1; i <= 6; i++) begin
            read_off(3'(i), v); e = exp_q.pop_front();
            n_checks++; if (v !== e) begin n_fail++; $display("FAIL areset_off sel %0d got %0d want %0d", i, v, e); end
        end
        full_step(3'd3, 1'b0);
        exp_q.push_back(8'(model[2]));
        read_off(3'd3, v); e = exp_q.pop_front();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL post_areset_step got %0d want %0d", v, e); end
        phasestep = 1'b1;
        scan_cycle();
        phasestep = 1'b0; #1;
        n_checks++; if (phase_done !== 1'b0) begin n_fail++; $display("FAIL busy_entry2 got %b want 0", phase_done); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (phase_done !== 1'b1 || rd_phase !== 8'd0 || step_total !== 16'd0) begin
            n_fail++; $display("FAIL async_reset done %b rd %0d total %0d want 1 0 0", phase_done, rd_phase, step_total);
        end
        @(posedge clk); #3 reset = 1'b0;
        model_clear();
        full_step(3'd3, 1'b1);
        exp_q.push_back(8'(model[2]));
        read_off(3'd3, v); e = exp_q.pop_front();
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL post_reset_step got %0d want %0d", v, e); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_all_down();
        test_wrap();
        test_hold();
        test_reserved();
        test_areset_busy();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_dps_responder.md
PLL_DPS_RESPONDER -- requirements
Module: pll_dps_responder

Interface
REQ-001 SHALL have parameter PHASE_MOD, default 24, number of phase positions per counter; offsets wrap modulo this value.
REQ-002 SHALL have parameter DONE_LAT, default 2, number of scanclk rising edges phase_done stays low per accepted step.
REQ-003 clk  input  1  system clock; one clock domain; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scanclk  input  1  initiator scan clock, asynchronous to clk.
REQ-006 phasestep  input  1  step request from the initiator.
REQ-007 phasecounterselect  input  3  target select: 000 all, 001 M, 010 C0, 011 C1, 100 C2, 101 C3, 110 C4, 111 reserved.
REQ-008 phaseupdown  input  1  step direction: 1 up, 0 down.
REQ-009 pll_areset  input  1  PLL reset from the initiator, level-sensitive.
REQ-010 phase_done  output  1  high when idle; low while a step is in progress.
REQ-011 rd_sel  input  3  readback select, same encoding as phasecounterselect.
REQ-012 rd_phase  output  8  registered offset of the counter selected by rd_sel.
REQ-013 sel_err  output  1  sticky flag for a reserved-select step.
REQ-014 step_total  output  16  count of accepted steps (see Configuration).

Function
REQ-015 SHALL synchronise scanclk, phasestep, phasecounterselect and phaseupdown through 2 flip-flops in clk before any use.
REQ-016 SHALL detect a scanclk rising edge (sr) as synced scanclk 0->1; all sampling of the control inputs SHALL occur only on sr cycles.
REQ-017 SHALL implement FSM states IDLE, BUSY, REARM.
REQ-018 IDLE: on sr with phasestep=1 and select != 111 -> BUSY; in that same cycle apply the step and register phase_done=0 at the following edge.
REQ-019 Step application: select 000 updates all six offsets; 001-110 update only the selected offset; the update is +1 if phaseupdown=1, else -1.
REQ-020 Offset arithmetic: value PHASE_MOD-1 plus 1 -> 0; value 0 minus 1 -> PHASE_MOD-1; offsets SHALL never hold a value >= PHASE_MOD.
REQ-021 IDLE: on sr with phasestep=1 and select=111, SHALL leave offsets unchanged, keep phase_done=1, set sel_err=1, and go to REARM.
REQ-022 BUSY: SHALL count sr edges; on the DONE_LAT-th edge, set phase_done=1 and go to REARM.
REQ-023 REARM: on sr with phasestep=0 -> IDLE; a phasestep held high SHALL never yield a second step.
REQ-024 Total latency from a raw scanclk rise to the phase_done fall SHALL be 4 clk cycles (2 sync + 1 edge detect + 1 output register).
REQ-025 pll_areset=1 SHALL clear all offsets to 0, force the FSM to IDLE and hold phase_done=1 each cycle; it overrides any simultaneous step.
REQ-026 rd_phase SHALL update 1 clk cycle after rd_sel or the offset changes; rd_sel=000 or 111 SHALL return the M offset.
REQ-027 sel_err SHALL clear only on reset or pll_areset.

Reset
REQ-028 reset=1 SHALL immediately force: FSM=IDLE, all offsets=0, phase_done=1, rd_phase=0, sel_err=0, step_total=0, and all synchroniser flops=0.
REQ-029 Deassertion SHALL take effect on the next clk edge; a scanclk already high at that point SHALL NOT produce an sr.

Configuration
REQ-030 Macro PLL_DPS_STEPLOG_EN.
- Defined: step_total SHALL increment by 1 per accepted step (REQ-018), saturate at 16'hFFFF, and clear on reset or pll_areset.
- Undefined: step_total SHALL be tied to 0 and the counter logic SHALL not exist.

Verification
REQ-031 Select 010, up, one step -> phase_done falls 4 clk after the scanclk rise, stays low for 2 sr, rd_sel=010 reads 1.
REQ-032 Select 000, down, from reset -> all six offsets read 23; step_total=1 with macro defined, 0 without.
REQ-033 24 up-steps on C4 -> rd_phase sequence 1..23 then 0; exactly 24 phase_done low pulses.
REQ-034 phasestep held high for 10 scanclk periods -> exactly one step; no second phase_done pulse until phasestep returns to 0.
REQ-035 Select 111 step -> offsets unchanged, phase_done stays 1, sel_err=1; pll_areset pulse -> sel_err=0.
REQ-036 pll_areset asserted mid-BUSY -> phase_done=1 the next cycle, offsets 0, FSM IDLE; reset mid-BUSY gives the same result asynchronously.
